// File: rtl/row_decompressor.sv
// ----------------------------------------------------------------------------
// row_decompressor
//   Rebuilds pixels from the row-compressed byte stream, one active frame at a
//   time. A previous-row line buffer supplies COPY tokens. The same buffer is
//   rewritten with every emitted pixel, so it always holds the most recent row.
//
//   Token format:
//     0nnnnnnn  COPY n+1 pixels from the previous row at the same column
//     10nnnnnn  REPEAT the last pixel of the current row n+1 times
//     11000000  LITERAL, followed by hi byte then lo byte
//     11xxxxxx  any other value is reserved: consumed, o_err pulse, no pixel
//
//   Optional feature (macro ROW_DECOMP_ROW_SYNC_EN):
//     0xFF is a row-sync marker. At column 0 it is consumed silently. At any
//     other column the rest of the row is skipped and o_err pulses.
//     When the macro is undefined, 0xFF is just another reserved token.
//
// Ports
//   CLK           system clock, all logic on posedge
//   RST           synchronous reset, active low
//   i_valid       upstream byte valid
//   i_byte        compressed byte
//   o_ready       byte accepted on posedge when i_valid && o_ready
//   o_pixel       reconstructed pixel (held stable while stalled)
//   o_valid       pixel valid
//   i_ready       downstream accepts pixel when o_valid && i_ready
//   o_x, o_y      column / row of o_pixel
//   o_frame_done  1-cycle pulse after the last pixel of a frame is accepted
//   o_err         1-cycle pulse on a protocol error
// ----------------------------------------------------------------------------
module row_decompressor #(
  parameter int ActiveFrameWidth  = 512,
  parameter int ActiveFrameHeight = 384,
  parameter int PixelBitWidth     = 16
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 i_valid,
  input  logic [7:0]                           i_byte,
  output logic                                 o_ready,
  output logic [PixelBitWidth-1:0]             o_pixel,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [$clog2(ActiveFrameWidth)-1:0]  o_x,
  output logic [$clog2(ActiveFrameHeight)-1:0] o_y,
  output logic                                 o_frame_done,
  output logic                                 o_err
);

  localparam int XW = $clog2(ActiveFrameWidth);
  localparam int YW = $clog2(ActiveFrameHeight);
  localparam logic [XW-1:0] XLast = XW'(ActiveFrameWidth - 1);
  localparam logic [YW-1:0] YLast = YW'(ActiveFrameHeight - 1);

  localparam logic [7:0] LitToken = 8'hC0;

  localparam logic [1:0] StCmd   = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StLitHi = 2'd2;
  localparam logic [1:0] StLitLo = 2'd3;

  logic [1:0]               state;
  logic [6:0]               run_cnt;    // pixels still to emit after the current one
  logic                     run_copy;   // 1 = COPY run, 0 = REPEAT run
  logic [7:0]               lit_hi;
  logic [XW-1:0]            x;          // column of the next pixel to emit
  logic [YW-1:0]            y;
  logic                     first_row;  // no valid previous row yet: COPY yields 0
  logic [PixelBitWidth-1:0] last_pix;
  logic                     out_last;   // pixel in the output register ends the frame

  logic [PixelBitWidth-1:0] line_buf [ActiveFrameWidth];

  logic                     out_free;
  logic                     byte_fire;
  logic                     emit;
  logic [PixelBitWidth-1:0] emit_pix;
  logic                     skip_row;
  logic                     advance_row;

  // The output register can take a new pixel when empty or being drained now.
  assign out_free  = !o_valid || i_ready;
  assign o_ready   = out_free && (state != StRun);
  assign byte_fire = i_valid && o_ready;

`ifdef ROW_DECOMP_ROW_SYNC_EN
  assign skip_row = (state == StCmd) && byte_fire && (i_byte == 8'hFF) && (x != '0);
`else
  assign skip_row = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    emit     = 1'b0;
    emit_pix = '0;
    if (state == StRun && out_free) begin
      emit     = 1'b1;
      emit_pix = run_copy ? (first_row ? '0 : line_buf[x]) : last_pix;
    end else if (state == StLitLo && byte_fire) begin
      emit     = 1'b1;
      emit_pix = PixelBitWidth'({lit_hi, i_byte});
    end
  end

  assign advance_row = (emit && (x == XLast)) || skip_row;

  // NOTE: the line buffer is deliberately left without reset; it is plain RAM and
  // first_row masks stale contents. The read above sees the old value in the
  // same cycle this write lands.
  always_ff @(posedge CLK) begin
    if (RST && emit) line_buf[x] <= emit_pix;
  end

  // NOTE: sequential state uses non-blocking assignments only, so later
  // assignments in this block (row start clearing last_pix) override earlier ones
  // without ordering hazards against other processes.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= StCmd;
      run_cnt      <= '0;
      run_copy     <= 1'b0;
      lit_hi       <= '0;
      x            <= '0;
      y            <= '0;
      first_row    <= 1'b1;
      last_pix     <= '0;
      out_last     <= 1'b0;
      o_pixel      <= '0;
      o_valid      <= 1'b0;
      o_x          <= '0;
      o_y          <= '0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_err        <= 1'b0;
      o_frame_done <= o_valid && i_ready && out_last;

      // Output register
      if (emit) begin
        o_pixel  <= emit_pix;
        o_valid  <= 1'b1;
        o_x      <= x;
        o_y      <= y;
        out_last <= (x == XLast) && (y == YLast);
        last_pix <= emit_pix;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end

      // Position: a new row starts with a cleared REPEAT source.
      if (advance_row) begin
        x        <= '0;
        last_pix <= '0;
        if (y == YLast) begin
          y         <= '0;
          first_row <= 1'b1;
        end else begin
          y         <= y + YW'(1);
          first_row <= 1'b0;
        end
      end else if (emit) begin
        x <= x + XW'(1);
      end

      case (state)
        StCmd: begin
          if (byte_fire) begin
            if (!i_byte[7]) begin
              state    <= StRun;
              run_copy <= 1'b1;
              run_cnt  <= i_byte[6:0];
            end else if (!i_byte[6]) begin
              state    <= StRun;
              run_copy <= 1'b0;
              run_cnt  <= {1'b0, i_byte[5:0]};
            end else if (i_byte == LitToken) begin
              state <= StLitHi;
            end
`ifdef ROW_DECOMP_ROW_SYNC_EN
            else if (i_byte == 8'hFF) begin
              o_err <= (x != '0);
            end
`endif
            else begin
              o_err <= 1'b1;
            end
          end
        end
        StRun: begin
          if (emit) begin
            if (run_cnt == '0) begin
              state <= StCmd;
            end else if (x == XLast) begin
              // Tokens never span rows: the remainder of the run is dropped.
              state <= StCmd;
              o_err <= 1'b1;
            end else begin
              run_cnt <= run_cnt - 7'd1;
            end
          end
        end
        StLitHi: begin
          if (byte_fire) begin
            lit_hi <= i_byte;
            state  <= StLitLo;
          end
        end
        StLitLo: begin
          if (byte_fire) state <= StCmd;
        end
        default: state <= StCmd;
      endcase
    end
  end

endmodule

// File: tb/tb_row_decompressor.sv
// ----------------------------------------------------------------------------
// tb_row_decompressor
//   Directed bench for row_decompressor, built with a full 512-pixel row and a
//   short 4-row frame so a whole frame fits in a short run. A negedge monitor
//   records every accepted pixel with its coordinates and counts o_err and
//   o_frame_done pulses; each scenario task drives bytes and compares the
//   recorded stream against hand-computed values.
// ----------------------------------------------------------------------------
module tb_row_decompressor;

  localparam int W = 512;
  localparam int H = 4;

`ifdef ROW_DECOMP_ROW_SYNC_EN
  localparam bit SyncEn = 1'b1;
`else
  localparam bit SyncEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [7:0]  i_byte;
  logic        o_ready;
  logic [15:0] o_pixel;
  logic        o_valid;
  logic        i_ready;
  logic [8:0]  o_x;
  logic [1:0]  o_y;
  logic        o_frame_done;
  logic        o_err;

  int tests = 0;
  int fails = 0;

  logic        ready_toggle = 1'b0;
  logic [15:0] pix_q[$];
  logic [8:0]  px_q[$];
  logic [1:0]  py_q[$];
  int          err_cnt = 0;
  int          fd_cnt  = 0;
  int          fd_at   = -1;

  row_decompressor #(
    .ActiveFrameWidth (W),
    .ActiveFrameHeight(H),
    .PixelBitWidth    (16)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .i_valid     (i_valid),
    .i_byte      (i_byte),
    .o_ready     (o_ready),
    .o_pixel     (o_pixel),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_x         (o_x),
    .o_y         (o_y),
    .o_frame_done(o_frame_done),
    .o_err       (o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready: held high, or toggled every cycle for backpressure.
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle) i_ready = ~i_ready;
      else i_ready = 1'b1;
    end
  end

  // Monitor: a pixel seen valid && ready here is taken on the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (o_frame_done) begin
          fd_cnt++;
          fd_at = pix_q.size();
        end
        if (o_err) err_cnt++;
        if (o_valid && i_ready) begin
          pix_q.push_back(o_pixel);
          px_q.push_back(o_x);
          py_q.push_back(o_y);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst     = 1'b0;
    i_valid = 1'b0;
    pix_q.delete();
    px_q.delete();
    py_q.delete();
    err_cnt = 0;
    fd_cnt  = 0;
    fd_at   = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    #1;
    i_valid = 1'b1;
    i_byte  = b;
    while (!o_ready && guard < 2000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!o_ready) begin
      tests++;
      fails++;
      $display("FAIL send_byte timeout: byte=%02h never accepted", b);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_pixels(input int n);
    int guard = 0;
    while (pix_q.size() < n && guard < 3000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (pix_q.size() < n) begin
      tests++;
      fails++;
      $display("FAIL wait_pixels timeout: got %0d pixels, required %0d", pix_q.size(), n);
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (o_valid !== 1'b0)      begin fails++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
    tests++; if (o_pixel !== 16'h0000)  begin fails++; $display("FAIL rst_pixel got=%h exp=0000", o_pixel); end
    tests++; if (o_x !== 9'd0)          begin fails++; $display("FAIL rst_x got=%0d exp=0", o_x); end
    tests++; if (o_y !== 2'd0)          begin fails++; $display("FAIL rst_y got=%0d exp=0", o_y); end
    tests++; if (o_frame_done !== 1'b0) begin fails++; $display("FAIL rst_frame_done got=%b exp=0", o_frame_done); end
    tests++; if (o_err !== 1'b0)        begin fails++; $display("FAIL rst_err got=%b exp=0", o_err); end
    tests++; if (o_ready !== 1'b1)      begin fails++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
  endtask

  // Literal, REPEAT of it, then COPY on the first row (source is zero).
  task automatic test_literal_repeat_copy();
    logic [15:0] exp_pix [6];
    exp_pix = '{16'h1234, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'h0000};
    do_reset();
    send_byte(8'hC0);
    send_byte(8'h12);
    send_byte(8'h34);
    tests++;
    if (o_valid !== 1'b1 || o_pixel !== 16'h1234) begin
      fails++;
      $display("FAIL lit_latency got valid=%b pixel=%h exp valid=1 pixel=1234", o_valid, o_pixel);
    end
    send_byte(8'h81);
    send_byte(8'h02);
    wait_pixels(6);
    tests++; if (pix_q.size() !== 6) begin fails++; $display("FAIL t1_count got=%0d exp=6", pix_q.size()); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (pix_q[i] !== exp_pix[i] || px_q[i] !== 9'(i) || py_q[i] !== 2'd0) begin
        fails++;
        $display("FAIL t1_pix%0d got=%h@(%0d,%0d) exp=%h@(%0d,0)", i, pix_q[i], px_q[i], py_q[i], exp_pix[i], i);
      end
    end
    tests++; if (err_cnt !== 0) begin fails++; $display("FAIL t1_err got=%0d exp=0", err_cnt); end
  endtask

  // Row 0 all zero, row 1 literal ABCD at x=0 then copies, row 2 copies ABCD back.
  task automatic test_copy_prev_row();
    logic [7:0] seq[$];
    int bad = 0;
    seq = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hC0, 8'hAB, 8'hCD, 8'h7F, 8'h7F, 8'h7F, 8'h7E, 8'h00};
    do_reset();
    foreach (seq[i]) send_byte(seq[i]);
    wait_pixels(1025);
    tests++; if (pix_q.size() !== 1025) begin fails++; $display("FAIL t2_count got=%0d exp=1025", pix_q.size()); end
    tests++;
    if (pix_q[511] !== 16'h0000 || px_q[511] !== 9'd511 || py_q[511] !== 2'd0) begin
      fails++; $display("FAIL t2_row0_end got=%h@(%0d,%0d) exp=0000@(511,0)", pix_q[511], px_q[511], py_q[511]);
    end
    tests++;
    if (pix_q[512] !== 16'hABCD || px_q[512] !== 9'd0 || py_q[512] !== 2'd1) begin
      fails++; $display("FAIL t2_row1_lit got=%h@(%0d,%0d) exp=abcd@(0,1)", pix_q[512], px_q[512], py_q[512]);
    end
    for (int i = 513; i <= 640; i++)
      if (pix_q[i] !== 16'h0000 || px_q[i] !== 9'(i - 512) || py_q[i] !== 2'd1) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL t2_row1_copy bad pixels got=%0d exp=0", bad); end
    tests++;
    if (pix_q[1024] !== 16'hABCD || px_q[1024] !== 9'd0 || py_q[1024] !== 2'd2) begin
      fails++; $display("FAIL t2_row2_copy got=%h@(%0d,%0d) exp=abcd@(0,2)", pix_q[1024], px_q[1024], py_q[1024]);
    end
    tests++; if (err_cnt !== 0) begin fails++; $display("FAIL t2_err got=%0d exp=0", err_cnt); end
  endtask

  // REPEAT 16 under toggling i_ready: held pixel stable, no byte taken mid-run.
  task automatic test_backpressure();
    int guard = 0;
    int ready_viol = 0;
    int stall_viol = 0;
    int bad = 0;
    logic prev_stalled = 1'b0;
    logic [15:0] prev_pix = '0;
    do_reset();
    send_byte(8'hC0);
    send_byte(8'h5A);
    send_byte(8'hA5);
    ready_toggle = 1'b1;
    send_byte(8'h8F);
    while (pix_q.size() < 17 && guard < 300) begin
      @(negedge clk);
      #1;
      if (o_ready && pix_q.size() <= 16) ready_viol++;
      if (prev_stalled && (o_pixel !== prev_pix || o_valid !== 1'b1)) stall_viol++;
      prev_stalled = o_valid && !i_ready;
      prev_pix     = o_pixel;
      guard++;
    end
    ready_toggle = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    tests++; if (pix_q.size() !== 17) begin fails++; $display("FAIL t3_count got=%0d exp=17", pix_q.size()); end
    for (int i = 1; i < 17; i++)
      if (pix_q[i] !== 16'h5AA5 || px_q[i] !== 9'(i)) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL t3_run_pixels bad got=%0d exp=0", bad); end
    tests++; if (ready_viol !== 0) begin fails++; $display("FAIL t3_ready_in_run got=%0d exp=0", ready_viol); end
    tests++; if (stall_viol !== 0) begin fails++; $display("FAIL t3_stall_stable got=%0d exp=0", stall_viol); end
    tests++; if (err_cnt !== 0) begin fails++; $display("FAIL t3_err got=%0d exp=0", err_cnt); end
  endtask

  // REPEAT 64 starting at x=500 is clamped to 12 pixels with an error.
  task automatic test_row_clamp();
    logic [7:0] seq[$];
    int bad = 0;
    seq = '{8'h7F, 8'h7F, 8'h7F, 8'h72, 8'hC0, 8'hBE, 8'hEF, 8'hBF,
            8'h80, 8'hC0, 8'h11, 8'h22, 8'h80};
    do_reset();
    foreach (seq[i]) send_byte(seq[i]);
    wait_pixels(515);
    tests++; if (pix_q.size() !== 515) begin fails++; $display("FAIL t4_count got=%0d exp=515", pix_q.size()); end
    tests++;
    if (pix_q[499] !== 16'hBEEF || px_q[499] !== 9'd499) begin
      fails++; $display("FAIL t4_lit got=%h@%0d exp=beef@499", pix_q[499], px_q[499]);
    end
    for (int i = 500; i < 512; i++)
      if (pix_q[i] !== 16'hBEEF || px_q[i] !== 9'(i) || py_q[i] !== 2'd0) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL t4_clamped_run bad got=%0d exp=0", bad); end
    tests++; if (err_cnt !== 1) begin fails++; $display("FAIL t4_err got=%0d exp=1", err_cnt); end
    tests++;
    if (pix_q[512] !== 16'h0000 || px_q[512] !== 9'd0 || py_q[512] !== 2'd1) begin
      fails++; $display("FAIL t4_row_start got=%h@(%0d,%0d) exp=0000@(0,1)", pix_q[512], px_q[512], py_q[512]);
    end
    tests++;
    if (pix_q[514] !== 16'h1122 || px_q[514] !== 9'd2 || py_q[514] !== 2'd1) begin
      fails++; $display("FAIL t4_repeat got=%h@(%0d,%0d) exp=1122@(2,1)", pix_q[514], px_q[514], py_q[514]);
    end
  endtask

  // Whole frame of literals; pixel i carries 0xC000 | i.
  task automatic test_frame();
    logic [15:0] v;
    int bad = 0;
    do_reset();
    for (int i = 0; i < W * H; i++) begin
      v = 16'hC000 | 16'(i);
      send_byte(8'hC0);
      send_byte(v[15:8]);
      send_byte(v[7:0]);
    end
    wait_pixels(W * H);
    tests++; if (pix_q.size() !== W * H) begin fails++; $display("FAIL t5_count got=%0d exp=%0d", pix_q.size(), W * H); end
    for (int i = 0; i < W * H; i++)
      if (pix_q[i] !== (16'hC000 | 16'(i)) || px_q[i] !== 9'(i % W) || py_q[i] !== 2'(i / W)) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL t5_pixels bad got=%0d exp=0", bad); end
    tests++; if (fd_cnt !== 1) begin fails++; $display("FAIL t5_frame_done_count got=%0d exp=1", fd_cnt); end
    tests++; if (fd_at !== W * H) begin fails++; $display("FAIL t5_frame_done_timing got=%0d exp=%0d", fd_at, W * H); end
    send_byte(8'h00);
    wait_pixels(W * H + 1);
    tests++;
    if (pix_q[W*H] !== 16'h0000 || px_q[W*H] !== 9'd0 || py_q[W*H] !== 2'd0) begin
      fails++; $display("FAIL t5_wrap_copy got=%h@(%0d,%0d) exp=0000@(0,0)", pix_q[W*H], px_q[W*H], py_q[W*H]);
    end
    tests++; if (fd_cnt !== 1) begin fails++; $display("FAIL t5_frame_done_once got=%0d exp=1", fd_cnt); end
  endtask

  // Reset mid-literal drops the partial token.
  task automatic test_reset_mid_literal();
    do_reset();
    send_byte(8'hC0);
    send_byte(8'h12);
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (pix_q.size() !== 0 || o_valid !== 1'b0) begin
      fails++; $display("FAIL t6_no_pixel got count=%0d valid=%b exp count=0 valid=0", pix_q.size(), o_valid);
    end
    do_reset();
    send_byte(8'h81);
    wait_pixels(2);
    tests++; if (pix_q.size() !== 2) begin fails++; $display("FAIL t6_count got=%0d exp=2", pix_q.size()); end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (pix_q[i] !== 16'h0000 || px_q[i] !== 9'(i) || py_q[i] !== 2'd0) begin
        fails++; $display("FAIL t6_pix%0d got=%h@(%0d,%0d) exp=0000@(%0d,0)", i, pix_q[i], px_q[i], py_q[i], i);
      end
    end
  endtask

  // 0xFF at x=0 and x=10, then a reserved token.
  task automatic test_ff_and_reserved();
    logic [8:0] exp_x10;
    logic [1:0] exp_y10;
    exp_x10 = SyncEn ? 9'd0 : 9'd10;
    exp_y10 = SyncEn ? 2'd1 : 2'd0;
    do_reset();
    send_byte(8'hFF);
    send_byte(8'h09);
    wait_pixels(10);
    tests++; if (err_cnt !== (SyncEn ? 0 : 1)) begin fails++; $display("FAIL t7_ff_x0_err got=%0d exp=%0d", err_cnt, SyncEn ? 0 : 1); end
    tests++; if (pix_q.size() !== 10) begin fails++; $display("FAIL t7_count10 got=%0d exp=10", pix_q.size()); end
    send_byte(8'hFF);
    send_byte(8'hC0);
    send_byte(8'h77);
    send_byte(8'h88);
    wait_pixels(11);
    tests++; if (err_cnt !== (SyncEn ? 1 : 2)) begin fails++; $display("FAIL t7_ff_x10_err got=%0d exp=%0d", err_cnt, SyncEn ? 1 : 2); end
    tests++;
    if (pix_q[10] !== 16'h7788 || px_q[10] !== exp_x10 || py_q[10] !== exp_y10) begin
      fails++; $display("FAIL t7_after_ff got=%h@(%0d,%0d) exp=7788@(%0d,%0d)", pix_q[10], px_q[10], py_q[10], exp_x10, exp_y10);
    end
    send_byte(8'hC1);
    send_byte(8'h80);
    wait_pixels(12);
    tests++; if (err_cnt !== (SyncEn ? 2 : 3)) begin fails++; $display("FAIL t7_reserved_err got=%0d exp=%0d", err_cnt, SyncEn ? 2 : 3); end
    tests++; if (pix_q.size() !== 12) begin fails++; $display("FAIL t7_count12 got=%0d exp=12", pix_q.size()); end
    tests++;
    if (pix_q[11] !== 16'h7788 || px_q[11] !== exp_x10 + 9'd1 || py_q[11] !== exp_y10) begin
      fails++; $display("FAIL t7_repeat got=%h@(%0d,%0d) exp=7788@(%0d,%0d)", pix_q[11], px_q[11], py_q[11], exp_x10 + 9'd1, exp_y10);
    end
  endtask

  initial begin
    rst     = 1'b0;
    i_valid = 1'b0;
    i_byte  = 8'h00;
    test_reset();
    test_literal_repeat_copy();
    test_copy_prev_row();
    test_backpressure();
    test_row_clamp();
    test_frame();
    test_reset_mid_literal();
    test_ff_and_reserved();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
